// File: rtl/sram_stream_reader_pkg.sv
// Shared width constants and FSM state encoding for the SRAM stream reader.
package sram_stream_reader_pkg;

  localparam int MAX_ADDR_WIDTH = 13;
  localparam int SRAM_WIDTH_O   = 8;
  localparam int NUM_SRAMS      = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// Two-entry FIFO with a registered head; caller guarantees no push when full
// and no pop when empty.
module sram_rd_fifo #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;

  // NOTE: both entries are reset so the visible head reads zero after reset;
  // with only two words this costs nothing and keeps the output deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= din;
          else                 tail_q <= din;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= din;
          end else begin
            head_q <= tail_q;
            tail_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = head_q;
  assign valid = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/sram_stream_reader.sv
// Streams len words from a 1-cycle-latency SRAM onto a valid/ready stream.
// Optional stall counter output enabled by defining SRAM_RD_STALL_CNT_EN.
module sram_stream_reader
  import sram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = MAX_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_WIDTH_O,
  parameter int LEN_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_data_o,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef SRAM_RD_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  state_t                state, state_next;
  logic                  done_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight, inflight_last;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic [DATA_WIDTH:0]   head;
  logic                  start_ok, pop, last_issue;

  assign start_ok   = (state == ST_IDLE) && start;
  assign pop        = m_valid && m_ready;
  // Words that will sit in the FIFO after this edge, plus the read issued now.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign sram_en    = (state == ST_READ) && (occupancy < 3'd2);
  assign sram_we    = 1'b0;
  assign sram_addr  = addr;
  assign last_issue = sram_en && (remaining == LEN_WIDTH'(1));
  assign busy       = (state != ST_IDLE);
  assign m_data     = head[DATA_WIDTH-1:0];
  assign m_last     = m_valid && head[DATA_WIDTH];

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) state_next = ST_READ;
          else           done_next  = 1'b1;
        end
      end
      ST_READ: begin
        if (last_issue) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && m_last) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= sram_en;
      inflight_last <= last_issue;
      if (start_ok) begin
        addr      <= base_addr;
        remaining <= len;
      end else if (sram_en) begin
        addr      <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  sram_rd_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  ({inflight_last, sram_data_o}),
    .pop  (pop),
    .dout (head),
    .valid(m_valid),
    .count(fifo_count)
  );

`ifdef SRAM_RD_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (busy && m_valid && !m_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: transfer-level model plus
// hand-computed expectations for latency, wrap, stall, reset and len=0.
module tb_sram_stream_reader;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int LW = 14;

  logic          clk = 1'b0;
  logic          rst, start, m_ready;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy, done, sram_en, sram_we, m_valid, m_last;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_o = '0;
  logic [DW-1:0] m_data;
`ifdef SRAM_RD_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  sram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_data_o(sram_data_o),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef SRAM_RD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h5A;
  endfunction

  // Synchronous SRAM: data appears the cycle after the enable.
  always @(posedge clk) if (sram_en) sram_data_o <= mem_word(sram_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transfer-level model state and per-transfer statistics.
  logic [AW-1:0] exp_addr_q[$];
  logic [DW:0]   exp_beat_q[$];
  logic [AW-1:0] addr_log[$];
  logic [DW:0]   beat;
  bit            model_busy, cur_busy, done_due, prev_stall;
  int            outstanding;
  int            t_start, t_first_en, t_last_en, t_first_valid, t_done_cyc;
  int            t_en_cnt, t_beats, t_done_cnt, t_max_out;
  logic [31:0]   model_stall;

  always @(negedge clk) begin
    if (rst) begin
      exp_addr_q.delete();
      exp_beat_q.delete();
      model_busy  = 1'b0;
      done_due    = 1'b0;
      prev_stall  = 1'b0;
      outstanding = 0;
      model_stall = '0;
    end else begin
      cur_busy = model_busy;
      check("busy", busy, cur_busy);
      check("done", done, done_due);
      check("sram_we", sram_we, 1'b0);
      if (done) begin
        t_done_cnt++;
        t_done_cyc = cyc;
      end
      if (!cur_busy) begin
        check("idle_sram_en", sram_en, 1'b0);
        check("idle_m_valid", m_valid, 1'b0);
      end
      if (prev_stall) check("valid_held", m_valid, 1'b1);
`ifdef SRAM_RD_STALL_CNT_EN
      check("stall_cnt", stall_cnt, model_stall);
`endif
      if (sram_en) begin
        if (exp_addr_q.size() == 0) check("extra_read", 1'b1, 1'b0);
        else check("sram_addr", sram_addr, exp_addr_q.pop_front());
        addr_log.push_back(sram_addr);
        if (t_first_en < 0) t_first_en = cyc;
        t_last_en = cyc;
        t_en_cnt++;
      end
      done_due = 1'b0;
      if (m_valid) begin
        if (t_first_valid < 0) t_first_valid = cyc;
        if (exp_beat_q.size() == 0) begin
          check("extra_beat", 1'b1, 1'b0);
        end else begin
          beat = exp_beat_q[0];
          check("m_data", m_data, beat[DW-1:0]);
          check("m_last", m_last, beat[DW]);
          if (m_ready) begin
            void'(exp_beat_q.pop_front());
            t_beats++;
            if (beat[DW]) begin
              model_busy = 1'b0;
              done_due   = 1'b1;
            end
          end
        end
      end
      outstanding = outstanding + int'(sram_en) - int'(m_valid && m_ready);
      check("outstanding_le_2", outstanding <= 2, 1'b1);
      if (outstanding > t_max_out) t_max_out = outstanding;
`ifdef SRAM_RD_STALL_CNT_EN
      if (start && !cur_busy) model_stall = '0;
      else if (cur_busy && m_valid && !m_ready && model_stall != '1) model_stall = model_stall + 1;
`endif
      if (start && !cur_busy) begin
        t_start = cyc; t_first_en = -1; t_last_en = -1; t_first_valid = -1;
        t_en_cnt = 0; t_beats = 0; t_done_cnt = 0; t_max_out = 0;
        addr_log.delete();
        if (len != '0) begin
          model_busy = 1'b1;
          for (int i = 0; i < int'(len); i++) begin
            exp_addr_q.push_back(base_addr + AW'(i));
            exp_beat_q.push_back({i == int'(len) - 1, mem_word(base_addr + AW'(i))});
          end
        end else begin
          done_due = 1'b1;
        end
      end
      prev_stall = m_valid && !m_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (t_done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, t_done_cnt != 0, 1'b1);
    tick();
    tick();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!m_valid && n < budget) begin
      tick();
      n++;
    end
    check({name, "_valid_seen"}, m_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sram_en", sram_en, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_sram_addr", sram_addr, 13'h0000);
    check("rst_m_data", m_data, 8'h00);
    rst = 1'b0;
    tick();

    // Basic transfer with a start pulse during busy that must be ignored.
    run_start(13'h0010, 14'd4);
    base_addr = 13'h0100; len = 14'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t1", 40);
    check("t1_en_cnt", t_en_cnt, 4);
    check("t1_addr0", addr_log[0], 13'h0010);
    check("t1_addr3", addr_log[3], 13'h0013);
    check("t1_first_en", t_first_en - t_start, 1);
    check("t1_en_span", t_last_en - t_first_en, 3);
    check("t1_first_valid", t_first_valid - t_start, 3);
    check("t1_beats", t_beats, 4);
    check("t1_done_cyc", t_done_cyc - t_start, 7);
    check("t1_done_cnt", t_done_cnt, 1);

    // Zero length: done next cycle, no SRAM access.
    run_start(13'h0055, 14'd0);
    wait_done("t2", 10);
    check("t2_en_cnt", t_en_cnt, 0);
    check("t2_no_valid", t_first_valid, -1);
    check("t2_done_cyc", t_done_cyc - t_start, 1);

    // Address wrap.
    run_start(13'h1FFE, 14'd4);
    wait_done("t3", 40);
    check("t3_addr0", addr_log[0], 13'h1FFE);
    check("t3_addr1", addr_log[1], 13'h1FFF);
    check("t3_addr2", addr_log[2], 13'h0000);
    check("t3_addr3", addr_log[3], 13'h0001);

    // Backpressure: ready low for 10 cycles from the first valid.
    m_ready = 1'b0;
    run_start(13'h0200, 14'd8);
    wait_valid("t4", 20);
    repeat (10) tick();
    check("t4_reads_stalled", t_en_cnt, 2);
    check("t4_max_out", t_max_out, 2);
    m_ready = 1'b1;
    wait_done("t4", 60);
    check("t4_beats", t_beats, 8);
    check("t4_done_cnt", t_done_cnt, 1);

    // Reset mid-transfer after 5 beats, then a fresh transfer.
    run_start(13'h0300, 14'd16);
    for (int n = 0; n < 40 && t_beats < 5; n++) tick();
    check("t5_beats_before_rst", t_beats, 5);
    rst = 1'b1;
    #1;
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_sram_en", sram_en, 1'b0);
    check("t5_sram_we", sram_we, 1'b0);
    check("t5_m_valid", m_valid, 1'b0);
    check("t5_m_last", m_last, 1'b0);
    check("t5_sram_addr", sram_addr, 13'h0000);
    check("t5_m_data", m_data, 8'h00);
`ifdef SRAM_RD_STALL_CNT_EN
    check("t5_stall_cnt", stall_cnt, 32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_start(13'h0040, 14'd3);
    wait_done("t5", 40);
    check("t5_new_beats", t_beats, 3);
    check("t5_new_addr2", addr_log[2], 13'h0042);
    check("t5_new_first_valid", t_first_valid - t_start, 3);

`ifdef SRAM_RD_STALL_CNT_EN
    // Three stalled cycles on a short transfer.
    run_start(13'h0080, 14'd4);
    wait_valid("t6", 20);
    m_ready = 1'b0;
    repeat (3) tick();
    m_ready = 1'b1;
    wait_done("t6", 40);
    check("t6_stall_cnt", stall_cnt, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
